// File: rtl/regfile_sb.sv
// Integer register file with read bypass and a pending late-write scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle write data onto the read ports.
module regfile_sb #(
    parameter int INIT_STYLE          = 2,
    parameter int REGISTER_WIDTH      = 32,
    parameter int REGISTER_ADDR_WIDTH = 5,
    parameter int NUM_READ            = 2
) (
    input  logic                                    cpu_clk,
    input  logic                                    cpu_rst_n,
    input  logic [NUM_READ*REGISTER_ADDR_WIDTH-1:0] rs_addr,
    output logic [NUM_READ*REGISTER_WIDTH-1:0]      rs_data,
    output logic [NUM_READ-1:0]                     rs_busy,
    input  logic                                    wa_we,
    input  logic [REGISTER_ADDR_WIDTH-1:0]          wa_addr,
    input  logic [REGISTER_WIDTH-1:0]               wa_data,
    input  logic                                    wb_we,
    input  logic [REGISTER_ADDR_WIDTH-1:0]          wb_addr,
    input  logic [REGISTER_WIDTH-1:0]               wb_data,
    input  logic                                    sb_set,
    input  logic [REGISTER_ADDR_WIDTH-1:0]          sb_addr,
    output logic [(2**REGISTER_ADDR_WIDTH)-1:0]     busy_vec,
    output logic [REGISTER_ADDR_WIDTH:0]            pending_cnt,
    output logic                                    wr_conflict
);

    localparam int W  = REGISTER_WIDTH;
    localparam int AW = REGISTER_ADDR_WIDTH;
    localparam int N  = 2**AW;
    localparam int CW = AW + 1;

    logic [N-1:0][W-1:0] rf;

    assign rf[0] = '0;

    for (genvar i = 1; i < N; i++) begin : g_reg
        localparam logic [W-1:0] INIT =
            (INIT_STYLE == 0) ? W'(i) :
            (INIT_STYLE == 1) ? W'(3 * i) : '0;
        logic [W-1:0] q;

        // Port A is the younger instruction, so it takes priority.
        always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
            if (!cpu_rst_n) begin
                q <= INIT;
            end else if (wa_we && wa_addr == AW'(i)) begin
                q <= wa_data;
            end else if (wb_we && wb_addr == AW'(i)) begin
                q <= wb_data;
            end
        end

        assign rf[i] = q;
    end

    logic          sb_hit;
    logic          wb_hit;
    logic          cnt_inc;
    logic          cnt_dec;
    logic [N-1:0]  busy_nxt;
    logic [CW-1:0] cnt_nxt;
    logic          conflict_nxt;

    assign sb_hit = sb_set && (sb_addr != '0);
    assign wb_hit = wb_we && (wb_addr != '0);

    // A new issue outranks the retirement of the previous late write.
    always_comb begin
        busy_nxt = busy_vec;
        if (wb_hit) begin
            busy_nxt[wb_addr] = 1'b0;
        end
        if (sb_hit) begin
            busy_nxt[sb_addr] = 1'b1;
        end
    end

    assign cnt_inc = sb_hit && !busy_vec[sb_addr];
    assign cnt_dec = wb_hit && busy_vec[wb_addr]
                     && !(sb_hit && sb_addr == wb_addr);
    assign cnt_nxt = pending_cnt + CW'(cnt_inc) - CW'(cnt_dec);

    assign conflict_nxt = wa_we && wb_we && (wa_addr == wb_addr)
                          && (wa_addr != '0);

    always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            busy_vec    <= '0;
            pending_cnt <= '0;
            wr_conflict <= 1'b0;
        end else begin
            busy_vec    <= busy_nxt;
            pending_cnt <= cnt_nxt;
            wr_conflict <= conflict_nxt;
        end
    end

    for (genvar k = 0; k < NUM_READ; k++) begin : g_rd
        logic [AW-1:0] a;
        logic [W-1:0]  d;
        logic          b;

        assign a = rs_addr[k*AW +: AW];

        always_comb begin
            d = rf[a];
            b = busy_vec[a];
`ifdef REGFILE_BYPASS_EN
            if (a != '0) begin
                if (wa_we && wa_addr == a) begin
                    d = wa_data;
                end else if (wb_we && wb_addr == a) begin
                    d = wb_data;
                end
                if (wb_we && wb_addr == a && !(sb_set && sb_addr == a)) begin
                    b = 1'b0;
                end
            end
`endif
        end

        assign rs_data[k*W +: W] = d;
        assign rs_busy[k]        = b;
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard-driven bench for regfile_sb built with INIT_STYLE=1.
// Expectations follow REGFILE_BYPASS_EN when the macro is defined.
module tb_regfile_sb;

    localparam int W  = 32;
    localparam int AW = 5;
    localparam int NR = 2;
    localparam int N  = 32;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic             cpu_clk = 1'b0;
    logic             cpu_rst_n = 1'b1;
    logic [NR*AW-1:0] rs_addr = '0;
    logic [NR*W-1:0]  rs_data;
    logic [NR-1:0]    rs_busy;
    logic             wa_we = 1'b0;
    logic [AW-1:0]    wa_addr = '0;
    logic [W-1:0]     wa_data = '0;
    logic             wb_we = 1'b0;
    logic [AW-1:0]    wb_addr = '0;
    logic [W-1:0]     wb_data = '0;
    logic             sb_set = 1'b0;
    logic [AW-1:0]    sb_addr = '0;
    logic [N-1:0]     busy_vec;
    logic [AW:0]      pending_cnt;
    logic             wr_conflict;

    typedef struct packed {
        logic [W-1:0] d;
        logic         b;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   n_checks = 0;
    int   n_fail = 0;

    regfile_sb #(
        .INIT_STYLE(1),
        .REGISTER_WIDTH(W),
        .REGISTER_ADDR_WIDTH(AW),
        .NUM_READ(NR)
    ) dut (
        .cpu_clk(cpu_clk),
        .cpu_rst_n(cpu_rst_n),
        .rs_addr(rs_addr),
        .rs_data(rs_data),
        .rs_busy(rs_busy),
        .wa_we(wa_we),
        .wa_addr(wa_addr),
        .wa_data(wa_data),
        .wb_we(wb_we),
        .wb_addr(wb_addr),
        .wb_data(wb_data),
        .sb_set(sb_set),
        .sb_addr(sb_addr),
        .busy_vec(busy_vec),
        .pending_cnt(pending_cnt),
        .wr_conflict(wr_conflict)
    );

    always #5 cpu_clk = ~cpu_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic push(input logic [W-1:0] d, input logic b);
        exp_t x;
        x.d = d;
        x.b = b;
        exp_q.push_back(x);
    endtask

    task automatic test_reset();
        cpu_rst_n = 1'b1;
        #3 cpu_rst_n = 1'b0;
        repeat (2) @(negedge cpu_clk);
        cpu_rst_n = 1'b1;
        rs_addr = {5'd31, 5'd5};
        push(32'd15, 1'b0);
        push(32'd93, 1'b0);
        #1;
        e = exp_q.pop_front();
        n_checks++;
        if (rs_data[31:0] !== e.d || rs_busy[0] !== e.b) begin
            n_fail++;
            $display("FAIL reset_x5: got %h/%b want %h/%b",
                     rs_data[31:0], rs_busy[0], e.d, e.b);
        end
        e = exp_q.pop_front();
        n_checks++;
        if (rs_data[63:32] !== e.d || rs_busy[1] !== e.b) begin
            n_fail++;
            $display("FAIL reset_x31: got %h/%b want %h/%b",
                     rs_data[63:32], rs_busy[1], e.d, e.b);
        end
        n_checks++;
        if (busy_vec !== '0 || pending_cnt !== '0 || wr_conflict !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: got %h/%0d/%b want 0/0/0",
                     busy_vec, pending_cnt, wr_conflict);
        end
        rs_addr = {5'd31, 5'd0};
        push(32'd0, 1'b0);
        #1;
        e = exp_q.pop_front();
        n_checks++;
        if (rs_data[31:0] !== e.d || rs_busy[0] !== e.b) begin
            n_fail++;
            $display("FAIL reset_x0: got %h/%b want %h/%b",
                     rs_data[31:0], rs_busy[0], e.d, e.b);
        end
    endtask

    task automatic test_port_a();
        @(negedge cpu_clk);
        wa_we = 1'b1;
        wa_addr = 5'd3;
        wa_data = 32'hDEADBEEF;
        rs_addr = {5'd0, 5'd3};
        push(BYP ? 32'hDEADBEEF : 32'd9, 1'b0);
        #1;
        e = exp_q.pop_front();
        n_checks++;
        if (rs_data[31:0] !== e.d) begin
            n_fail++;
            $display("FAIL porta_same_cycle: got %h want %h", rs_data[31:0], e.d);
        end
        @(negedge cpu_clk);
        wa_we = 1'b0;
        push(32'hDEADBEEF, 1'b0);
        #1;
        e = exp_q.pop_front();
        n_checks++;
        if (rs_data[31:0] !== e.d) begin
            n_fail++;
            $display("FAIL porta_next_cycle: got %h want %h", rs_data[31:0], e.d);
        end
    endtask

    task automatic test_conflict();
        @(negedge cpu_clk);
        wa_we = 1'b1;
        wa_addr = 5'd7;
        wa_data = 32'h11;
        wb_we = 1'b1;
        wb_addr = 5'd7;
        wb_data = 32'h22;
        rs_addr = {5'd0, 5'd7};
        #1;
        n_checks++;
        if (wr_conflict !== 1'b0) begin
            n_fail++;
            $display("FAIL conflict_early: got %b want 0", wr_conflict);
        end
        @(negedge cpu_clk);
        wa_we = 1'b0;
        wb_we = 1'b0;
        push(32'h11, 1'b0);
        #1;
        e = exp_q.pop_front();
        n_checks++;
        if (rs_data[31:0] !== e.d) begin
            n_fail++;
            $display("FAIL conflict_a_wins: got %h want %h", rs_data[31:0], e.d);
        end
        n_checks++;
        if (wr_conflict !== 1'b1) begin
            n_fail++;
            $display("FAIL conflict_pulse: got %b want 1", wr_conflict);
        end
        @(negedge cpu_clk);
        #1;
        n_checks++;
        if (wr_conflict !== 1'b0) begin
            n_fail++;
            $display("FAIL conflict_one_cycle: got %b want 0", wr_conflict);
        end
        wa_we = 1'b1;
        wa_addr = 5'd0;
        wa_data = 32'hAAAA5555;
        wb_we = 1'b1;
        wb_addr = 5'd0;
        wb_data = 32'h5555AAAA;
        rs_addr = {5'd0, 5'd0};
        @(negedge cpu_clk);
        wa_we = 1'b0;
        wb_we = 1'b0;
        push(32'd0, 1'b0);
        #1;
        e = exp_q.pop_front();
        n_checks++;
        if (rs_data[31:0] !== e.d || wr_conflict !== 1'b0) begin
            n_fail++;
            $display("FAIL conflict_x0: got %h/%b want %h/0",
                     rs_data[31:0], wr_conflict, e.d);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] v;
        for (int j = 0; j < 5; j++) begin
            @(negedge cpu_clk);
            if (j < 4) begin
                v = $urandom();
                wa_we = 1'b1;
                wa_addr = AW'(10 + j);
                wa_data = v;
                push(v, 1'b0);
            end else begin
                wa_we = 1'b0;
            end
            if (j > 0) begin
                rs_addr[9:5] = AW'(9 + j);
                #1;
                e = exp_q.pop_front();
                n_checks++;
                if (rs_data[63:32] !== e.d) begin
                    n_fail++;
                    $display("FAIL b2b_x%0d: got %h want %h",
                             9 + j, rs_data[63:32], e.d);
                end
            end
        end
    endtask

    task automatic test_scoreboard();
        @(negedge cpu_clk);
        sb_set = 1'b1;
        sb_addr = 5'd9;
        rs_addr = {5'd0, 5'd9};
        @(negedge cpu_clk);
        sb_set = 1'b0;
        #1;
        n_checks++;
        if (rs_busy[0] !== 1'b1 || pending_cnt !== 6'd1 || busy_vec !== 32'h200) begin
            n_fail++;
            $display("FAIL sb_set_x9: got %b/%0d/%h want 1/1/00000200",
                     rs_busy[0], pending_cnt, busy_vec);
        end
        repeat (3) @(negedge cpu_clk);
        wb_we = 1'b1;
        wb_addr = 5'd9;
        wb_data = 32'h55;
        push(BYP ? 32'h55 : 32'd27, BYP ? 1'b0 : 1'b1);
        #1;
        e = exp_q.pop_front();
        n_checks++;
        if (rs_data[31:0] !== e.d || rs_busy[0] !== e.b) begin
            n_fail++;
            $display("FAIL sb_retire_same: got %h/%b want %h/%b",
                     rs_data[31:0], rs_busy[0], e.d, e.b);
        end
        @(negedge cpu_clk);
        wb_we = 1'b0;
        push(32'h55, 1'b0);
        #1;
        e = exp_q.pop_front();
        n_checks++;
        if (rs_data[31:0] !== e.d || rs_busy[0] !== e.b || pending_cnt !== '0) begin
            n_fail++;
            $display("FAIL sb_retire_next: got %h/%b/%0d want %h/%b/0",
                     rs_data[31:0], rs_busy[0], pending_cnt, e.d, e.b);
        end
    endtask

    task automatic test_set_clr_same();
        @(negedge cpu_clk);
        sb_set = 1'b1;
        sb_addr = 5'd4;
        rs_addr = {5'd0, 5'd4};
        @(negedge cpu_clk);
        wb_we = 1'b1;
        wb_addr = 5'd4;
        wb_data = 32'h44;
        push(BYP ? 32'h44 : 32'd12, 1'b1);
        #1;
        e = exp_q.pop_front();
        n_checks++;
        if (rs_data[31:0] !== e.d || rs_busy[0] !== e.b) begin
            n_fail++;
            $display("FAIL setclr_same_cycle: got %h/%b want %h/%b",
                     rs_data[31:0], rs_busy[0], e.d, e.b);
        end
        @(negedge cpu_clk);
        wb_we = 1'b0;
        sb_addr = 5'd0;
        push(32'h44, 1'b1);
        #1;
        e = exp_q.pop_front();
        n_checks++;
        if (rs_data[31:0] !== e.d || rs_busy[0] !== e.b || pending_cnt !== 6'd1) begin
            n_fail++;
            $display("FAIL setclr_after: got %h/%b/%0d want %h/%b/1",
                     rs_data[31:0], rs_busy[0], pending_cnt, e.d, e.b);
        end
        @(negedge cpu_clk);
        sb_set = 1'b0;
        rs_addr = {5'd4, 5'd0};
        #1;
        n_checks++;
        if (pending_cnt !== 6'd1 || busy_vec !== 32'h10 || rs_busy[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL sb_set_x0: got %0d/%h/%b want 1/00000010/0",
                     pending_cnt, busy_vec, rs_busy[0]);
        end
        wb_we = 1'b1;
        wb_addr = 5'd4;
        wb_data = 32'h4;
        @(negedge cpu_clk);
        wb_we = 1'b0;
        #1;
        n_checks++;
        if (pending_cnt !== '0 || busy_vec !== '0) begin
            n_fail++;
            $display("FAIL setclr_drain: got %0d/%h want 0/0", pending_cnt, busy_vec);
        end
    endtask

    task automatic test_async_reset();
        for (int j = 1; j <= 3; j++) begin
            @(negedge cpu_clk);
            sb_set = 1'b1;
            sb_addr = AW'(j);
        end
        @(negedge cpu_clk);
        sb_set = 1'b0;
        rs_addr = {5'd1, 5'd3};
        #1;
        n_checks++;
        if (pending_cnt !== 6'd3 || busy_vec !== 32'hE) begin
            n_fail++;
            $display("FAIL pre_reset: got %0d/%h want 3/0000000e", pending_cnt, busy_vec);
        end
        #1 cpu_rst_n = 1'b0;
        push(32'd9, 1'b0);
        push(32'd3, 1'b0);
        #1;
        n_checks++;
        if (pending_cnt !== '0 || busy_vec !== '0 || wr_conflict !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset_sb: got %0d/%h/%b want 0/0/0",
                     pending_cnt, busy_vec, wr_conflict);
        end
        e = exp_q.pop_front();
        n_checks++;
        if (rs_data[31:0] !== e.d || rs_busy[0] !== e.b) begin
            n_fail++;
            $display("FAIL async_reset_x3: got %h/%b want %h/%b",
                     rs_data[31:0], rs_busy[0], e.d, e.b);
        end
        e = exp_q.pop_front();
        n_checks++;
        if (rs_data[63:32] !== e.d || rs_busy[1] !== e.b) begin
            n_fail++;
            $display("FAIL async_reset_x1: got %h/%b want %h/%b",
                     rs_data[63:32], rs_busy[1], e.d, e.b);
        end
        @(negedge cpu_clk);
        cpu_rst_n = 1'b1;
        @(negedge cpu_clk);
    endtask

    initial begin
        test_reset();
        test_port_a();
        test_conflict();
        test_back_to_back();
        test_scoreboard();
        test_set_clr_same();
        test_async_reset();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL queue_drain: got %0d entries want 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
